// File: rtl/ff_pkg.sv
// Shared definitions for the ff_reg_multi register bank.
// Mode encoding is common to RTL and testbench.
package ff_pkg;

    typedef enum logic [1:0] {
        FF_D     = 2'b00,
        FF_T     = 2'b01,
        FF_JK    = 2'b10,
        FF_SHIFT = 2'b11
    } ff_mode_t;

endpackage

// File: rtl/ff_bit.sv
// One-bit next-state cell for ff_reg_multi.
// Purely combinational; the register lives in the top level.
module ff_bit
    import ff_pkg::*;
(
    input  logic     q_cur,
    input  ff_mode_t mode,
    input  logic     d,
    input  logic     k,
    input  logic     shift_in,
    output logic     q_nxt
);

    always_comb begin
        q_nxt = q_cur;
        unique case (mode)
            FF_D:     q_nxt = d;
            FF_T:     q_nxt = q_cur ^ d;
            FF_JK: begin
                unique case ({d, k})
                    2'b00:   q_nxt = q_cur;
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    default: q_nxt = ~q_cur;
                endcase
            end
            default:  q_nxt = shift_in;
        endcase
    end

endmodule

// File: rtl/ff_reg_multi.sv
// WIDTH-bit register bank with D/T/JK/shift modes,
// complementary outputs and a registered change pulse.
module ff_reg_multi
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  ff_mode_t         mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic             chg
);

    logic [WIDTH-1:0] r_q;
    logic             r_chg;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_shin;

    // Right shift: each bit takes its upper neighbour, MSB takes sin
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_msb
            assign w_shin[i] = sin;
        end else begin : g_mid
            assign w_shin[i] = r_q[i+1];
        end

        ff_bit u_bit (
            .q_cur    (r_q[i]),
            .mode     (mode),
            .d        (d[i]),
            .k        (k[i]),
            .shift_in (w_shin[i]),
            .q_nxt    (w_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= RESET_VAL;
            r_chg <= 1'b0;
        end else if (en) begin
            r_q   <= w_nxt;
            r_chg <= (w_nxt != r_q);
        end else begin
            r_chg <= 1'b0;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;
    assign sout = r_q[0];
    assign chg  = r_chg;

endmodule

// File: tb/tb_ff_reg_multi.sv
// Testbench for ff_reg_multi: 8-bit and 1-bit instances checked
// against a vector-level reference model plus literal expectations.
module tb_ff_reg_multi;
    import ff_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    ff_mode_t   mode = FF_D;
    logic [7:0] d = 8'hFF;
    logic [7:0] k = 8'h00;
    logic       sin = 1'b0;

    logic [7:0] q8, qb8;
    logic       so8, ch8;
    logic [0:0] q1, qb1;
    logic       so1, ch1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ff_reg_multi #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .d(d), .k(k), .sin(sin),
        .q(q8), .qbar(qb8), .sout(so8), .chg(ch8)
    );

    ff_reg_multi #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .d(d[0:0]), .k(k[0:0]), .sin(sin),
        .q(q1), .qbar(qb1), .sout(so1), .chg(ch1)
    );

    // Reference model: whole-vector arithmetic from the mode rules
    logic [7:0] m_q8;
    logic       m_c8;
    logic       m_q1;
    logic       m_c1;
    logic       m_ok = 1'b0;

    function automatic logic [7:0] ref_nxt(
        input logic [7:0] q, input ff_mode_t m,
        input logic [7:0] dd, input logic [7:0] kk, input logic s);
        case (m)
            FF_D:    return dd;
            FF_T:    return q ^ dd;
            FF_JK:   return (dd & ~kk) | (q & ~dd & ~kk) | (~q & dd & kk);
            default: return {s, q[7:1]};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [7:0] n8;
        logic       n1;
        if (rst) begin
            m_q8 = 8'hA5;
            m_c8 = 1'b0;
            m_q1 = 1'b0;
            m_c1 = 1'b0;
            m_ok = 1'b1;
        end else if (en) begin
            n8   = ref_nxt(m_q8, mode, d, k, sin);
            n1   = (mode == FF_SHIFT) ? sin
                 : ref_nxt({7'd0, m_q1}, mode, d, k, sin) & 1'b1;
            m_c8 = (n8 != m_q8);
            m_c1 = (n1 != m_q1);
            m_q8 = n8;
            m_q1 = n1;
        end else begin
            m_c8 = 1'b0;
            m_c1 = 1'b0;
        end
    end

    task automatic cmp(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (m_ok) begin
            cmp("q8", q8, m_q8);
            cmp("qbar8", qb8, ~m_q8);
            cmp("sout8", {7'd0, so8}, {7'd0, m_q8[0]});
            cmp("chg8", {7'd0, ch8}, {7'd0, m_c8});
            cmp("q1", {7'd0, q1}, {7'd0, m_q1});
            cmp("qbar1", {7'd0, qb1}, {7'd0, ~m_q1});
            cmp("sout1", {7'd0, so1}, {7'd0, m_q1});
            cmp("chg1", {7'd0, ch1}, {7'd0, m_c1});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Literal check of both the DUT and the model
    task automatic lit(input string nm, input logic [7:0] eq,
                       input logic ec);
        cmp({nm, "_q"}, q8, eq);
        cmp({nm, "_qbar"}, qb8, ~eq);
        cmp({nm, "_chg"}, {7'd0, ch8}, {7'd0, ec});
        cmp({nm, "_model"}, m_q8, eq);
    endtask

    initial begin
        // Reset, held with en/D active
        step();
        lit("rst", 8'hA5, 1'b0);
        cmp("rst_sout", {7'd0, so8}, 8'd1);
        step();
        lit("rst_hold", 8'hA5, 1'b0);

        // D load then enable-low hold
        rst = 1'b0; d = 8'h3C;
        step();
        lit("dload", 8'h3C, 1'b1);
        en = 1'b0; d = 8'hFF;
        repeat (3) step();
        lit("hold", 8'h3C, 1'b0);

        // Toggle
        en = 1'b1; mode = FF_T; d = 8'h0F;
        step();
        lit("t1", 8'h33, 1'b1);
        step();
        lit("t2", 8'h3C, 1'b1);
        d = 8'h00;
        step();
        lit("t0", 8'h3C, 1'b0);

        // JK covering all four input pairs
        mode = FF_D; d = 8'hF0;
        step();
        mode = FF_JK; d = 8'hCC; k = 8'hAA;
        step();
        lit("jk", 8'h5C, 1'b1);

        // Full 8-edge shift of ones from zero
        mode = FF_D; d = 8'h00;
        step();
        mode = FF_SHIFT; sin = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            logic [7:0] ones;
            ones = 8'hFF;
            step();
            lit("shift", ~(ones >> n), 1'b1);
            cmp("shift_sout", {7'd0, so8}, (n == 8) ? 8'd1 : 8'd0);
            cmp("shift_w1", {7'd0, q1}, 8'd1);
        end
        step();
        lit("shift_sat", 8'hFF, 1'b0);

        // Reset aborting a shift sequence at edge 4
        mode = FF_D; d = 8'h00;
        step();
        mode = FF_SHIFT;
        repeat (3) step();
        lit("pre_abort", 8'hE0, 1'b1);
        rst = 1'b1;
        step();
        lit("abort", 8'hA5, 1'b0);
        rst = 1'b0; sin = 1'b0;
        step();
        lit("post_abort", 8'h52, 1'b1);
        cmp("w1_sin0", {7'd0, q1}, 8'd0);

        // Random traffic, checked by the per-cycle compare
        for (int i = 0; i < 10000; i++) begin
            rst  = ($urandom_range(0, 31) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = ff_mode_t'($urandom_range(0, 3));
            d    = 8'($urandom);
            k    = 8'($urandom);
            sin  = 1'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
